// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for the pipelined barrel shifter.
// master drives operands and out_ready; slave is the shifter.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 68,
    parameter int AMT_W = 7,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter (SRL/SRA/SLL/ROR) with
// valid/ready flow control and a sideband tag per operand.
module pipelined_barrel_shifter #(
    parameter int WIDTH       = 68,
    parameter int AMT_W       = 7,
    parameter int LVL_PER_STG = 2,
    parameter int TAG_W       = 4
) (
    input logic clk,
    input logic rst,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int LVLS = $clog2(WIDTH);
    localparam int NSTG = (LVLS + LVL_PER_STG - 1) / LVL_PER_STG;
    localparam int AIW  = (AMT_W > 1) ? $clog2(AMT_W) : 1;

    localparam logic [1:0] MODE_SRL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_SLL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    localparam logic [AMT_W:0] WID_A = WIDTH[AMT_W:0];

    logic [NSTG-1:0]  vld_q, vld_d;
    logic [NSTG-1:0]  adv;
    logic [WIDTH-1:0] data_q [NSTG];
    logic [WIDTH-1:0] data_d [NSTG];
    logic [AMT_W-1:0] amt_q  [NSTG];
    logic [AMT_W-1:0] amt_d  [NSTG];
    logic [1:0]       mode_q [NSTG];
    logic [1:0]       mode_d [NSTG];
    logic [TAG_W-1:0] tag_q  [NSTG];
    logic [TAG_W-1:0] tag_d  [NSTG];
    logic             rdy_q, rdy_d;

    logic [NSTG-1:0]  src_vld;
    logic [WIDTH-1:0] src_data [NSTG];
    logic [AMT_W-1:0] src_amt  [NSTG];
    logic [1:0]       src_mode [NSTG];
    logic [TAG_W-1:0] src_tag  [NSTG];

    logic             in_fire;
    logic             over;
    logic [AMT_W:0]   amt_mod;
    logic [WIDTH-1:0] pre_data;
    logic [AMT_W-1:0] pre_amt;

    // One mux level: shift by s in the given mode
    function automatic logic [WIDTH-1:0] lvl(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input int unsigned      s
    );
        logic [WIDTH-1:0] r;
        unique case (m)
            MODE_SRL: r = d >> s;
            MODE_SRA: r = WIDTH'($signed(d) >>> s);
            MODE_SLL: r = d << s;
            default:  r = (d >> s) | (d << (WIDTH - s));
        endcase
        return r;
    endfunction

    // Levels owned by stage k, each gated by its amount bit
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] d,
        input logic [AMT_W-1:0] a,
        input logic [1:0]       m,
        input int               k
    );
        logic [WIDTH-1:0] r;
        int i;
        r = d;
        for (int j = 0; j < LVL_PER_STG; j++) begin
            i = k * LVL_PER_STG + j;
            if (i < LVLS) begin
                if (a[i[AIW-1:0]]) r = lvl(r, m, 32'd1 << i);
            end
        end
        return r;
    endfunction

    // Stage k may move when any stage from k onward has a hole
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        adv = '0;
        for (int k = NSTG - 1; k >= 0; k--) begin
            all_full = all_full & vld_q[k];
            adv[k] = bus.out_ready | ~all_full;
        end
    end

    assign rdy_d        = 1'b1;
    assign bus.in_ready = adv[0] & rdy_q;
    assign in_fire      = bus.in_valid & bus.in_ready;

    // Resolve over-range amounts before any mux level
    always_comb begin
        over     = {1'b0, bus.in_amt} >= WID_A;
        amt_mod  = {1'b0, bus.in_amt} % WID_A;
        pre_data = bus.in_data;
        pre_amt  = bus.in_amt;
        if (over) begin
            unique case (bus.in_mode)
                MODE_SRL, MODE_SLL: begin
                    pre_data = '0;
                    pre_amt  = '0;
                end
                MODE_SRA: begin
                    pre_data = {WIDTH{bus.in_data[WIDTH-1]}};
                    pre_amt  = '0;
                end
                default: pre_amt = amt_mod[AMT_W-1:0];
            endcase
        end
    end

    // Source of each stage: the input port or the previous stage
    always_comb begin
        src_vld[0]  = in_fire;
        src_data[0] = pre_data;
        src_amt[0]  = pre_amt;
        src_mode[0] = bus.in_mode;
        src_tag[0]  = bus.in_tag;
        for (int k = 1; k < NSTG; k++) begin
            src_vld[k]  = vld_q[k-1];
            src_data[k] = data_q[k-1];
            src_amt[k]  = amt_q[k-1];
            src_mode[k] = mode_q[k-1];
            src_tag[k]  = tag_q[k-1];
        end
    end

    // Advance or hold every stage register
    always_comb begin
        for (int k = 0; k < NSTG; k++) begin
            vld_d[k]  = vld_q[k];
            data_d[k] = data_q[k];
            amt_d[k]  = amt_q[k];
            mode_d[k] = mode_q[k];
            tag_d[k]  = tag_q[k];
            if (adv[k]) begin
                vld_d[k]  = src_vld[k];
                data_d[k] = stage_shift(src_data[k], src_amt[k],
                                        src_mode[k], k);
                amt_d[k]  = src_amt[k];
                mode_d[k] = src_mode[k];
                tag_d[k]  = src_tag[k];
            end
        end
    end

    // Pipeline state; reset drops everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            rdy_q <= 1'b0;
            for (int k = 0; k < NSTG; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            vld_q <= vld_d;
            rdy_q <= rdy_d;
            for (int k = 0; k < NSTG; k++) begin
                data_q[k] <= data_d[k];
                amt_q[k]  <= amt_d[k];
                mode_q[k] <= mode_d[k];
                tag_q[k]  <= tag_d[k];
            end
        end
    end

    assign bus.out_valid = vld_q[NSTG-1];
    assign bus.out_data  = data_q[NSTG-1];
    assign bus.out_tag   = tag_q[NSTG-1];
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter:
// directed corner cases plus randomized traffic vs a model.
module tb_pipelined_barrel_shifter;
    localparam int W    = 68;
    localparam int A    = 7;
    localparam int T    = 4;
    localparam int NSTG = 4;

    localparam logic [1:0] SRL = 2'b00;
    localparam logic [1:0] SRA = 2'b01;
    localparam logic [1:0] SLL = 2'b10;
    localparam logic [1:0] ROR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pipelined_barrel_shifter_if #(.WIDTH(W), .AMT_W(A), .TAG_W(T)) bus ();

    pipelined_barrel_shifter #(
        .WIDTH(W), .AMT_W(A), .LVL_PER_STG(2), .TAG_W(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Whole-word reference: one shift of the full amount
    function automatic logic [W-1:0] ref_shift(
        input logic [W-1:0] d,
        input logic [A-1:0] a,
        input logic [1:0]   m
    );
        int unsigned sa;
        int unsigned r;
        sa = a;
        unique case (m)
            SRL: return (sa >= W) ? '0 : d >> sa;
            SRA: return (sa >= W) ? {W{d[W-1]}} : W'($signed(d) >>> sa);
            SLL: return (sa >= W) ? '0 : d << sa;
            default: begin
                r = sa % W;
                if (r == 0) return d;
                return (d >> r) | (d << (W - r));
            end
        endcase
    endfunction

    // Issue one operand into an idle pipe and wait for its result
    task automatic run_op(
        input  logic [W-1:0] d,
        input  logic [A-1:0] a,
        input  logic [1:0]   m,
        input  logic [T-1:0] t,
        output logic [W-1:0] od,
        output logic [T-1:0] ot,
        output int           lat,
        output logic         acc
    );
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_amt    = a;
        bus.in_mode   = m;
        bus.in_tag    = t;
        bus.out_ready = 1'b1;
        #1 acc = bus.in_ready;
        lat = -1;
        od  = '0;
        ot  = '0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (lat < 0 && bus.out_valid === 1'b1) begin
                lat = c;
                od  = bus.out_data;
                ot  = bus.out_tag;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_out_valid got %b exp 0", bus.out_valid);
        end
        n_checks++;
        if (bus.out_data !== '0) begin
            n_fail++;
            $display("FAIL rst_out_data got %h exp 0", bus.out_data);
        end
        n_checks++;
        if (bus.out_tag !== '0) begin
            n_fail++;
            $display("FAIL rst_out_tag got %h exp 0", bus.out_tag);
        end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_ready got %b exp 0", bus.in_ready);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rel_in_ready got %b exp 0", bus.in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_rst_in_ready got %b exp 1", bus.in_ready);
        end
    endtask

    task automatic test_srl();
        logic [W-1:0] od;
        logic [T-1:0] ot;
        int lat;
        logic acc;
        run_op(68'h8_0000_0000_0000_0001, 7'd1, SRL, 4'h3,
               od, ot, lat, acc);
        n_checks++;
        if (acc !== 1'b1 || od !== 68'h4_0000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL srl1 got %h acc %b exp %h", od, acc,
                     68'h4_0000_0000_0000_0000);
        end
        n_checks++;
        if (lat != NSTG) begin
            n_fail++;
            $display("FAIL latency got %0d exp %0d", lat, NSTG);
        end
        n_checks++;
        if (ot !== 4'h3) begin
            n_fail++;
            $display("FAIL srl1_tag got %h exp 3", ot);
        end
    endtask

    task automatic test_over_range();
        logic [W-1:0] od;
        logic [T-1:0] ot;
        int lat;
        logic acc;
        run_op(68'h8_0000_0000_0000_0000, 7'd67, SRA, 4'h1,
               od, ot, lat, acc);
        n_checks++;
        if (od !== {W{1'b1}}) begin
            n_fail++;
            $display("FAIL sra67 got %h exp all ones", od);
        end
        run_op(68'h8_0000_0000_0000_0000, 7'd100, SRA, 4'h2,
               od, ot, lat, acc);
        n_checks++;
        if (od !== {W{1'b1}}) begin
            n_fail++;
            $display("FAIL sra100 got %h exp all ones", od);
        end
        run_op(68'h7_FFFF_FFFF_FFFF_FFFF, 7'd100, SRA, 4'h3,
               od, ot, lat, acc);
        n_checks++;
        if (od !== '0) begin
            n_fail++;
            $display("FAIL sra100_pos got %h exp 0", od);
        end
        run_op(68'hF_FFFF_FFFF_FFFF_FFFF, 7'd100, SRL, 4'h4,
               od, ot, lat, acc);
        n_checks++;
        if (od !== '0) begin
            n_fail++;
            $display("FAIL srl100 got %h exp 0", od);
        end
        run_op(68'hF_FFFF_FFFF_FFFF_FFFF, 7'd68, SLL, 4'h5,
               od, ot, lat, acc);
        n_checks++;
        if (od !== '0) begin
            n_fail++;
            $display("FAIL sll68 got %h exp 0", od);
        end
    endtask

    task automatic test_ror();
        logic [W-1:0] od;
        logic [T-1:0] ot;
        logic [W-1:0] d;
        int lat;
        logic acc;
        run_op(68'h1, 7'd4, ROR, 4'h6, od, ot, lat, acc);
        n_checks++;
        if (od !== 68'h1_0000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL ror4 got %h exp %h", od,
                     68'h1_0000_0000_0000_0000);
        end
        run_op(68'h1, 7'd72, ROR, 4'h7, od, ot, lat, acc);
        n_checks++;
        if (od !== 68'h1_0000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL ror72 got %h exp %h", od,
                     68'h1_0000_0000_0000_0000);
        end
        d = W'({$urandom(), $urandom(), $urandom()});
        run_op(d, 7'd127, ROR, 4'h8, od, ot, lat, acc);
        n_checks++;
        if (od !== ref_shift(d, 7'd127, ROR)) begin
            n_fail++;
            $display("FAIL ror127 got %h exp %h", od,
                     ref_shift(d, 7'd127, ROR));
        end
    endtask

    task automatic test_sll_amt0();
        logic [W-1:0] od;
        logic [T-1:0] ot;
        logic [W-1:0] d;
        int lat;
        logic acc;
        run_op(68'hF, 7'd64, SLL, 4'h9, od, ot, lat, acc);
        n_checks++;
        if (od !== 68'hF_0000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL sll64 got %h exp %h", od,
                     68'hF_0000_0000_0000_0000);
        end
        for (int m = 0; m < 4; m++) begin
            d = W'({$urandom(), $urandom(), $urandom()});
            d[W-1] = 1'b1;
            run_op(d, 7'd0, 2'(m), 4'(m), od, ot, lat, acc);
            n_checks++;
            if (od !== d || ot !== 4'(m)) begin
                n_fail++;
                $display("FAIL amt0_mode%0d got %h exp %h", m, od, d);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W+T-1:0] q[$];
        logic [W+T-1:0] e;
        logic [W-1:0]   d;
        logic [A-1:0]   a;
        logic [1:0]     m;
        logic [W-1:0]   pd;
        logic [T-1:0]   pt;
        logic           stall;
        int issued;
        int got;
        int cyc;
        issued = 0;
        got    = 0;
        cyc    = 0;
        stall  = 1'b0;
        pd     = '0;
        pt     = '0;
        while ((issued < 32 || got < 32) && cyc < 2000) begin
            if (stall) begin
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== pd ||
                    bus.out_tag !== pt) begin
                    n_fail++;
                    $display("FAIL stall_hold got %b %h %h exp 1 %h %h",
                             bus.out_valid, bus.out_data, bus.out_tag,
                             pd, pt);
                end
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            if (issued < 32 && $urandom_range(0, 3) != 0) begin
                d = W'({$urandom(), $urandom(), $urandom()});
                a = A'($urandom_range(0, 127));
                m = 2'($urandom_range(0, 3));
                bus.in_valid = 1'b1;
                bus.in_data  = d;
                bus.in_amt   = a;
                bus.in_mode  = m;
                bus.in_tag   = 4'(issued);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra got %h exp none",
                             bus.out_data);
                end else begin
                    e = q.pop_front();
                    if (bus.out_data !== e[W+T-1:T] ||
                        bus.out_tag !== e[T-1:0]) begin
                        n_fail++;
                        $display("FAIL b2b_result got %h/%h exp %h/%h",
                                 bus.out_data, bus.out_tag,
                                 e[W+T-1:T], e[T-1:0]);
                    end
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                q.push_back({ref_shift(d, a, m), 4'(issued)});
                issued++;
            end
            stall = (bus.out_valid === 1'b1) && !bus.out_ready;
            pd = bus.out_data;
            pt = bus.out_tag;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++;
        if (issued != 32 || got != 32 || q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count got %0d/%0d left %0d exp 32/32/0",
                     issued, got, q.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] od;
        logic [T-1:0] ot;
        logic [W-1:0] d;
        int lat;
        int stale;
        logic acc;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = W'({$urandom(), $urandom(), $urandom()});
            bus.in_amt   = A'(i + 1);
            bus.in_mode  = SRL;
            bus.in_tag   = 4'(10 + i);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_clear got %b/%b exp 0/0",
                     bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL midrst_stale got %0d exp 0", stale);
        end
        d = W'({$urandom(), $urandom(), $urandom()});
        run_op(d, 7'd37, SRA, 4'hE, od, ot, lat, acc);
        n_checks++;
        if (acc !== 1'b1 || lat != NSTG || ot !== 4'hE ||
            od !== ref_shift(d, 7'd37, SRA)) begin
            n_fail++;
            $display("FAIL midrst_next got %h lat %0d tag %h exp %h %0d E",
                     od, lat, ot, ref_shift(d, 7'd37, SRA), NSTG);
        end
    endtask

    initial begin
        test_reset();
        test_srl();
        test_over_range();
        test_ror();
        test_sll_amt0();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
